// File: rtl/uc_mult_pkg.sv
// uc_mult_pkg -- shared definitions for the shift-and-add multiplier control unit.
//   state_t      : FSM state encoding (IDLE, LOAD, TEST, ADD, SHIFT, DONE)
//   N_DEFAULT    : default operand width / iteration count
//   CW_DEFAULT   : default iteration counter width
//   cw_for()     : counter width needed to count 0..n-1 (minimum 1)
package uc_mult_pkg;

  function automatic int cw_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int N_DEFAULT  = 3;
  localparam int CW_DEFAULT = cw_for(N_DEFAULT);

  // Six legal encodings out of eight; the remaining two are decoded as
  // illegal and steer the FSM back to IDLE.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/contador_uc.sv
// contador_uc -- iteration counter for the multiplier control unit.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, clears the count
//   clear : synchronous clear (issued in LOAD)
//   inc   : advance by one; ignored once terminal count is reached
//   tc    : high when count == N-1
module contador_uc #(
  parameter int N  = 3,
  parameter int CW = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic tc
);

  logic [CW-1:0] count;

  assign tc = (count == CW'(N - 1));

  // The count saturates at N-1 rather than wrapping; only clear or reset
  // bring it back to zero.
  always_ff @(posedge clk) begin
    // NOTE: registered state is updated with non-blocking assignments so every
    // flop samples pre-edge values, independent of process ordering.
    if (reset || clear) begin
      count <= '0;
    end else if (inc && !tc) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uc_mult.sv
// uc_mult -- Moore control unit for an N-bit shift-and-add multiplier.
// The datapath (M, Q and A registers, adder) lives outside this block and is
// driven by the strobes below; q0 reports the multiplier LSB back.
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset (aborts any operation)
//   start     : begin a multiplication; sampled only in IDLE
//   q0        : LSB of the multiplier shift register
//   CargaM    : load multiplicand register
//   CargaQ    : parallel-load multiplier register
//   DesplazaQ : shift multiplier register right (0 into MSB)
//   InicA     : clear accumulator/product register
//   CargaA    : load accumulator with A + M
//   DesplazaA : shift accumulator/product register
//   Fin       : one-cycle pulse, product valid
//   Ocupado   : high in every state except IDLE
module uc_mult
  import uc_mult_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q0,
  output logic CargaM,
  output logic CargaQ,
  output logic DesplazaQ,
  output logic InicA,
  output logic CargaA,
  output logic DesplazaA,
  output logic Fin,
  output logic Ocupado
);

  state_t state, state_next;
  logic   cnt_clear, cnt_inc, cnt_tc;

  contador_uc #(
    .N  (N),
    .CW (CW)
  ) u_contador (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs depend on the registered state only; q0, start and cnt_tc
  // influence the next state and the counter controls, never the strobes.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_next = IDLE;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    CargaM     = 1'b0;
    CargaQ     = 1'b0;
    DesplazaQ  = 1'b0;
    InicA      = 1'b0;
    CargaA     = 1'b0;
    DesplazaA  = 1'b0;
    Fin        = 1'b0;
    Ocupado    = 1'b1;

    case (state)
      IDLE: begin
        Ocupado    = 1'b0;
        state_next = start ? LOAD : IDLE;
      end
      LOAD: begin
        CargaM     = 1'b1;
        CargaQ     = 1'b1;
        InicA      = 1'b1;
        cnt_clear  = 1'b1;
        state_next = TEST;
      end
      TEST: begin
        state_next = q0 ? ADD : SHIFT;
      end
      ADD: begin
        CargaA     = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        DesplazaQ = 1'b1;
        DesplazaA = 1'b1;
        if (cnt_tc) begin
          state_next = DONE;
        end else begin
          cnt_inc    = 1'b1;
          state_next = TEST;
        end
      end
      DONE: begin
        Fin        = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uc_mult.sv
// tb_uc_mult -- self-checking bench for uc_mult (N = 3).
// A small multiplier register model feeds q0 from the DUT strobes; expected
// per-cycle output vectors come from the operation's definition: LOAD, then
// per multiplier bit TEST, ADD if the bit is 1, SHIFT, then DONE and IDLE.
module tb_uc_mult;

  localparam int N = 3;

  typedef logic [7:0] ov_t;  // {CargaM,CargaQ,DesplazaQ,InicA,CargaA,DesplazaA,Fin,Ocupado}

  localparam ov_t V_IDLE  = 8'b0000_0000;
  localparam ov_t V_LOAD  = 8'b1101_0001;
  localparam ov_t V_TEST  = 8'b0000_0001;
  localparam ov_t V_ADD   = 8'b0000_1001;
  localparam ov_t V_SHIFT = 8'b0010_0101;
  localparam ov_t V_DONE  = 8'b0000_0011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic q0;
  logic CargaM, CargaQ, DesplazaQ, InicA, CargaA, DesplazaA, Fin, Ocupado;

  logic [N-1:0] mult = '0;
  logic [N-1:0] q_reg = '0;
  ov_t          obs;
  ov_t          exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uc_mult dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .q0        (q0),
    .CargaM    (CargaM),
    .CargaQ    (CargaQ),
    .DesplazaQ (DesplazaQ),
    .InicA     (InicA),
    .CargaA    (CargaA),
    .DesplazaA (DesplazaA),
    .Fin       (Fin),
    .Ocupado   (Ocupado)
  );

  assign obs = {CargaM, CargaQ, DesplazaQ, InicA, CargaA, DesplazaA, Fin, Ocupado};

  // External multiplier register, as the datapath would hold it.
  always @(posedge clk) begin
    if (CargaQ === 1'b1)         q_reg <= mult;
    else if (DesplazaQ === 1'b1) q_reg <= {1'b0, q_reg[N-1:1]};
  end
  assign q0 = q_reg[0];

  // Expected output stream for one multiplication, followed by one IDLE cycle.
  task automatic build_seq(input logic [N-1:0] m);
    exp_q = {};
    exp_q.push_back(V_LOAD);
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(V_TEST);
      if (m[i]) exp_q.push_back(V_ADD);
      exp_q.push_back(V_SHIFT);
    end
    exp_q.push_back(V_DONE);
    exp_q.push_back(V_IDLE);
  endtask

  // One start pulse; optional extra start pulse driven during cycle pulse_at.
  task automatic run_mult(input logic [N-1:0] m, input int pulse_at, input string tag);
    int fin_cyc, n_fin, n_add, n_shq, lat;
    build_seq(m);
    lat = 1 + 2 * N + $countones(m) + 1;
    fin_cyc = 0; n_fin = 0; n_add = 0; n_shq = 0;
    @(negedge clk);
    mult  = m;
    start = 1'b1;
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clk);
      start = (c == pulse_at);
      n_cmp++;
      if (obs !== exp_q[c-1]) begin
        n_bad++;
        $display("FAIL %s cycle %0d: outputs %b, expected %b", tag, c, obs, exp_q[c-1]);
      end
      n_cmp++;
      if ((CargaQ === 1'b1 && DesplazaQ === 1'b1) || (CargaA === 1'b1 && DesplazaA === 1'b1)) begin
        n_bad++;
        $display("FAIL %s exclusive cycle %0d: outputs %b, expected no load+shift pair", tag, c, obs);
      end
      if (Fin === 1'b1) begin fin_cyc = c; n_fin++; end
      if (CargaA === 1'b1) n_add++;
      if (DesplazaQ === 1'b1) n_shq++;
    end
    start = 1'b0;
    n_cmp++;
    if (fin_cyc != lat || n_fin != 1) begin
      n_bad++;
      $display("FAIL %s latency: Fin at cycle %0d (%0d pulses), expected cycle %0d (1 pulse)", tag, fin_cyc, n_fin, lat);
    end
    n_cmp++;
    if (n_add != $countones(m)) begin
      n_bad++;
      $display("FAIL %s add_count: %0d CargaA pulses, expected %0d", tag, n_add, $countones(m));
    end
    n_cmp++;
    if (n_shq != N) begin
      n_bad++;
      $display("FAIL %s shift_count: %0d DesplazaQ pulses, expected %0d", tag, n_shq, N);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs !== V_IDLE) begin
      n_bad++;
      $display("FAIL reset_held: outputs %b, expected %b", obs, V_IDLE);
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== V_IDLE) begin
      n_bad++;
      $display("FAIL reset_release: outputs %b, expected %b", obs, V_IDLE);
    end
  endtask

  task automatic test_directed();
    run_mult(3'b101, 0, "m101");
    run_mult(3'b000, 0, "m000");
    run_mult(3'b111, 0, "m111");
  endtask

  task automatic test_start_ignored();
    run_mult(3'b101, 4, "start_in_cycle4");
  endtask

  task automatic test_reset_mid();
    int rc, n_sh;
    build_seq(3'b101);
    rc = 0; n_sh = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i] == V_SHIFT) begin
        n_sh++;
        if (n_sh == 2 && rc == 0) rc = i + 1;
      end
    end
    @(negedge clk);
    mult  = 3'b101;
    start = 1'b1;
    for (int c = 1; c <= rc; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (obs !== exp_q[c-1]) begin
        n_bad++;
        $display("FAIL reset_mid cycle %0d: outputs %b, expected %b", c, obs, exp_q[c-1]);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (obs !== V_IDLE) begin
      n_bad++;
      $display("FAIL reset_mid_abort: outputs %b, expected %b", obs, V_IDLE);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== V_IDLE) begin
        n_bad++;
        $display("FAIL reset_mid_quiet cycle %0d: outputs %b, expected %b", c, obs, V_IDLE);
      end
    end
    run_mult(3'b101, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    ov_t one[$];
    int  len, fin1, fin2;
    build_seq(3'b101);
    one = exp_q;
    len = one.size();
    exp_q = {one, one};
    fin1 = 0; fin2 = 0;
    @(negedge clk);
    mult  = 3'b101;
    start = 1'b1;
    for (int c = 1; c <= 2 * len; c++) begin
      @(negedge clk);
      if (c == 2 * len - 1) start = 1'b0;
      n_cmp++;
      if (obs !== exp_q[c-1]) begin
        n_bad++;
        $display("FAIL back_to_back cycle %0d: outputs %b, expected %b", c, obs, exp_q[c-1]);
      end
      if (Fin === 1'b1) begin
        if (fin1 == 0) fin1 = c;
        else fin2 = c;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (fin1 == 0 || fin2 - fin1 != len) begin
      n_bad++;
      $display("FAIL back_to_back_period: Fin at %0d and %0d, expected spacing %0d", fin1, fin2, len);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] m;
    int lat, p;
    for (int k = 0; k < 10; k++) begin
      m   = N'($urandom_range(0, (1 << N) - 1));
      lat = 1 + 2 * N + $countones(m) + 1;
      p   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, lat - 1)) : 0;
      run_mult(m, p, $sformatf("rand%0d_m%b_p%0d", k, m, p));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
